// File: rtl/prio_rr_arbiter.sv
// Registered N-way arbiter with fixed-priority or round-robin selection and a
// sticky valid/ready grant towards a single consumer.
module prio_rr_arbiter #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic         valid_d;
  logic [W-1:0] idx_d;
  logic [N-1:0] onehot_d;
  logic [W-1:0] ptr_d;
  logic [W-1:0] sel_c;
  logic         any_req_c;

  // Fixed: highest set index. Round-robin: first set bit at or below p, wrapping.
  function automatic logic [W-1:0] pick(input logic [N-1:0] r, input logic m,
                                        input logic [W-1:0] p);
    logic [W-1:0] s;
    int           j;
    s = '0;
    if (!m) begin
      for (int i = 0; i < int'(N); i++) begin
        if (r[W'(i)]) s = W'(i);
      end
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        j = int'(p) - k;
        if (j < 0) j = j + int'(N);
        if (r[W'(j)]) s = W'(j);
      end
    end
    return s;
  endfunction

  assign any_req_c = |req;

  always_comb begin
    state_d  = state_q;
    valid_d  = grant_valid;
    idx_d    = grant_idx;
    onehot_d = grant_onehot;
    ptr_d    = ptr;
    sel_c    = '0;

    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          sel_c    = pick(req, mode, ptr);
          valid_d  = 1'b1;
          idx_d    = sel_c;
          onehot_d = N'(1) << sel_c;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          if (mode) ptr_d = (grant_idx == '0) ? W'(N - 1) : grant_idx - W'(1);
          if (any_req_c) begin
            // Back-to-back grant picks against the pointer as updated this edge.
            sel_c    = pick(req, mode, ptr_d);
            idx_d    = sel_c;
            onehot_d = N'(1) << sel_c;
          end else begin
            valid_d  = 1'b0;
            idx_d    = '0;
            onehot_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      ptr          <= W'(N - 1);
    end else begin
      state_q      <= state_d;
      grant_valid  <= valid_d;
      grant_idx    <= idx_d;
      grant_onehot <= onehot_d;
      ptr          <= ptr_d;
    end
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter (N=8): expected grant state is queued per
// step and compared after the clock edge.
module tb_prio_rr_arbiter;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef struct {
    logic         valid;
    logic [W-1:0] idx;
    logic [N-1:0] onehot;
    logic [W-1:0] ptr;
    string        tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         mode;
  logic         grant_ready;
  logic         grant_valid;
  logic [W-1:0] grant_idx;
  logic [N-1:0] grant_onehot;
  logic [W-1:0] ptr;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  prio_rr_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mode         (mode),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .ptr          (ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then compare.
  task automatic step(input string tag, input logic rst_v, input logic [N-1:0] r,
                      input logic m, input logic rdy,
                      input logic e_valid, input int e_idx, input int e_ptr);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n       = rst_v;
    req         = r;
    mode        = m;
    grant_ready = rdy;
    e.valid  = e_valid;
    e.idx    = W'(e_idx);
    e.onehot = e_valid ? (N'(1) << e_idx) : '0;
    e.ptr    = W'(e_ptr);
    e.tag    = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({got.tag, ".valid"},  32'(grant_valid),  32'(got.valid));
    check({got.tag, ".idx"},    32'(grant_idx),    32'(got.idx));
    check({got.tag, ".onehot"}, 32'(grant_onehot), 32'(got.onehot));
    check({got.tag, ".ptr"},    32'(ptr),          32'(got.ptr));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; mode = 1'b0; grant_ready = 1'b0;

    // Reset with all requests asserted
    step("reset0", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 7);
    step("reset1", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 7);

    // Fixed priority: idx 5 every cycle, ptr untouched
    for (int i = 0; i < 5; i++)
      step($sformatf("fixed%0d", i), 1'b1, 8'b0010_1100, 1'b0, 1'b1, 1'b1, 5, 7);
    step("fixed_drain", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 0, 7);

    // Round-robin rotation 7..0,7 with no bubble
    for (int i = 0; i < 9; i++)
      step($sformatf("rr%0d", i), 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, (7 - i) & 7, (7 - i) & 7);
    step("rr_drain", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 0, 6);

    // Sticky grant under stall, requester drops mid-stall
    step("stall0", 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 4, 6);
    for (int i = 1; i < 5; i++)
      step($sformatf("stall%0d", i), 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 4, 6);
    step("stall_acc", 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 0, 3);

    // Pointer wrap from 0 back to N-1
    step("wrap_g1", 1'b1, 8'h02,        1'b1, 1'b1, 1'b1, 1, 7);
    step("wrap_g0", 1'b1, 8'b1000_0001, 1'b1, 1'b1, 1'b1, 0, 0);
    step("wrap_g7", 1'b1, 8'b1000_0001, 1'b1, 1'b1, 1'b1, 7, 7);

    // Mode change while stalled keeps the held grant; next pick is fixed
    step("mode_hold", 1'b1, 8'b1000_0001, 1'b0, 1'b0, 1'b1, 7, 7);
    step("mode_fix",  1'b1, 8'h03,        1'b0, 1'b1, 1'b1, 1, 7);

    // Reset mid-grant, ready while idle ignored, then re-grant
    step("pre_rst",   1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 3, 0);
    step("mid_rst",   1'b0, 8'h08, 1'b1, 1'b1, 1'b0, 0, 7);
    step("idle_rdy",  1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 0, 7);
    step("post_rst",  1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 3, 7);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
